// File: rtl/serial_parity_unit.sv
// rtl/serial_parity_unit.sv - frame-based serial parity generator/checker
// Accepts DATA_BITS serial bits per frame, then emits (gen) or checks (check) a parity bit.
module serial_parity_unit #(
  parameter int DATA_BITS = 8,
  parameter bit ODD       = 1'b0,
  parameter int ERR_W     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             mode,
  input  logic                             x_valid,
  input  logic                             x,
  output logic                             run_par,
  output logic [$clog2(DATA_BITS+1)-1:0]   bit_cnt,
  output logic                             busy,
  output logic                             p_valid,
  output logic                             p_bit,
  output logic                             frame_done,
  output logic                             par_err,
  output logic [ERR_W-1:0]                 err_cnt
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t             state_q;
  logic               acc_q;
  logic               mode_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               p_valid_q;
  logic               p_bit_q;
  logic               frame_done_q;
  logic               par_err_q;
  logic [ERR_W-1:0]   err_cnt_q;
  logic [ERR_W-1:0]   err_cnt_d;
  logic               mismatch;

  assign mismatch  = (x != (acc_q ^ ODD));
  assign err_cnt_d = (err_cnt_q != ERR_MAX) ? err_cnt_q + ERR_W'(1) : err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= 1'b0;
      mode_q       <= 1'b0;
      bit_cnt_q    <= '0;
      p_valid_q    <= 1'b0;
      p_bit_q      <= 1'b0;
      frame_done_q <= 1'b0;
      par_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      p_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      par_err_q    <= 1'b0;
      if (clr) begin
        // Abort keeps err_cnt and the last p_bit for status readout.
        state_q   <= IDLE;
        acc_q     <= 1'b0;
        bit_cnt_q <= '0;
      end else if (x_valid) begin
        case (state_q)
          IDLE: begin
            mode_q    <= mode;
            acc_q     <= x;
            bit_cnt_q <= CNT_W'(1);
            state_q   <= DATA;
          end
          DATA: begin
            acc_q     <= acc_q ^ x;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_CNT) begin
              if (!mode_q) begin
                p_bit_q      <= acc_q ^ x ^ ODD;
                p_valid_q    <= 1'b1;
                frame_done_q <= 1'b1;
                state_q      <= IDLE;
              end else begin
                state_q <= PARITY;
              end
            end
          end
          PARITY: begin
            p_bit_q      <= x;
            p_valid_q    <= 1'b1;
            frame_done_q <= 1'b1;
            par_err_q    <= mismatch;
            if (mismatch) begin
              err_cnt_q <= err_cnt_d;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign run_par    = acc_q;
  assign bit_cnt    = bit_cnt_q;
  assign busy       = (state_q != IDLE);
  assign p_valid    = p_valid_q;
  assign p_bit      = p_bit_q;
  assign frame_done = frame_done_q;
  assign par_err    = par_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_serial_parity_unit.sv
// tb/tb_serial_parity_unit.sv - scoreboard bench for serial_parity_unit
// Two instances (even/ERR_W=8 and odd/ERR_W=2) share one randomized stimulus stream.
module tb_serial_parity_unit;

  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic mode = 1'b0;
  logic x_valid = 1'b0;
  logic x = 1'b0;

  logic       rp0, bz0, pv0, pb0, fd0, pe0;
  logic [3:0] bc0;
  logic [7:0] ec0;
  logic       rp1, bz1, pv1, pb1, fd1, pe1;
  logic [3:0] bc1;
  logic [1:0] ec1;

  serial_parity_unit #(.DATA_BITS(DB), .ODD(1'b0), .ERR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .x_valid(x_valid), .x(x),
    .run_par(rp0), .bit_cnt(bc0), .busy(bz0), .p_valid(pv0), .p_bit(pb0),
    .frame_done(fd0), .par_err(pe0), .err_cnt(ec0)
  );

  serial_parity_unit #(.DATA_BITS(DB), .ODD(1'b1), .ERR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .x_valid(x_valid), .x(x),
    .run_par(rp1), .bit_cnt(bc1), .busy(bz1), .p_valid(pv1), .p_bit(pb1),
    .frame_done(fd1), .par_err(pe1), .err_cnt(ec1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pb;
    logic pe;
    int   ec;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: the frame is just the list of data bits accepted so far.
  int bits[$];
  bit active;
  bit awaiting;
  bit mode_m;
  int ec_m[2];
  int odd_p[2] = '{0, 1};
  int emax[2]  = '{255, 3};

  function automatic int xor_all();
    int r = 0;
    foreach (bits[i]) r = r ^ bits[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic push_exp(input int i, input int pb, input int pe);
    exp_t e;
    e.pb = pb[0];
    e.pe = pe[0];
    e.ec = ec_m[i];
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic model_reset();
    bits.delete();
    active = 0;
    awaiting = 0;
    mode_m = 0;
    ec_m[0] = 0;
    ec_m[1] = 0;
  endtask

  task automatic model_accept(input int xb, input int m);
    int par;
    if (!active) begin
      bits.delete();
      bits.push_back(xb);
      mode_m = m[0];
      active = 1;
    end else if (awaiting) begin
      par = xor_all();
      for (int i = 0; i < 2; i++) begin
        int err;
        err = (xb != (par ^ odd_p[i])) ? 1 : 0;
        if (err == 1 && ec_m[i] < emax[i]) ec_m[i]++;
        push_exp(i, xb, err);
      end
      active = 0;
      awaiting = 0;
    end else begin
      bits.push_back(xb);
      if (bits.size() == DB) begin
        if (!mode_m) begin
          par = xor_all();
          for (int i = 0; i < 2; i++) push_exp(i, par ^ odd_p[i], 0);
          active = 0;
        end else begin
          awaiting = 1;
        end
      end
    end
  endtask

  task automatic mon(input int i, input logic pv, input logic fd, input logic pe,
                     input logic pb, input int ec);
    exp_t e;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      chk($sformatf("unexpected_pulse%0d", i), 1, 0);
    end else begin
      if (i == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk($sformatf("p_valid%0d", i), pv, 1);
      chk($sformatf("frame_done%0d", i), fd, 1);
      chk($sformatf("par_err%0d", i), pe, e.pe);
      chk($sformatf("p_bit%0d", i), pb, e.pb);
      chk($sformatf("pulse_err_cnt%0d", i), ec, e.ec);
    end
  endtask

  always @(negedge clk) begin
    if (pv0 || fd0 || pe0) mon(0, pv0, fd0, pe0, pb0, int'(ec0));
    if (pv1 || fd1 || pe1) mon(1, pv1, fd1, pe1, pb1, int'(ec1));
  end

  task automatic check_state();
    int cnt;
    int rp;
    cnt = bits.size();
    rp = xor_all();
    chk("pulse_on_time0", q0.size(), 0);
    chk("pulse_on_time1", q1.size(), 0);
    chk("bit_cnt0", bc0, cnt);
    chk("bit_cnt1", bc1, cnt);
    chk("run_par0", rp0, rp);
    chk("run_par1", rp1, rp);
    chk("busy0", bz0, active);
    chk("busy1", bz1, active);
    chk("err_cnt0", ec0, ec_m[0]);
    chk("err_cnt1", ec1, ec_m[1]);
  endtask

  task automatic step(input int v, input int xb, input int m, input int c);
    x_valid = v[0];
    x = xb[0];
    mode = m[0];
    clr = c[0];
    @(posedge clk);
    if (c != 0) begin
      bits.delete();
      active = 0;
      awaiting = 0;
    end else if (v != 0) begin
      model_accept(xb, m);
    end
    @(negedge clk);
    #1;
    check_state();
  endtask

  task automatic check_all_zero();
    chk("rst_outs0", {rp0, bc0, bz0, pv0, pb0, fd0, pe0, ec0}, 0);
    chk("rst_outs1", {rp1, bc1, bz1, pv1, pb1, fd1, pe1, ec1}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    q0.delete();
    q1.delete();
    x_valid = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero();
  endtask

  task automatic send_frame(input logic [7:0] d, input int m, input int par);
    for (int k = 0; k < DB; k++) step(1, d[7-k], m, 0);
    if (m != 0) step(1, par, m, 0);
  endtask

  initial begin
    logic [7:0] f;
    int p;
    model_reset();
    #1;
    check_all_zero();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero();

    // Generate: 1,0,1,1,0,0,0,1 -> even 0, odd 1.
    send_frame(8'b1011_0001, 0, 0);
    step(0, 0, 0, 0);
    // Check with wrong (even) parity 1, then correct parity 0.
    send_frame(8'b1011_0001, 1, 1);
    send_frame(8'b1011_0001, 1, 0);
    // Gap of three idle cycles after bit 4.
    f = 8'b1011_0001;
    for (int k = 0; k < 4; k++) step(1, f[7-k], 0, 0);
    repeat (3) step(0, 1, 1, 0);
    for (int k = 4; k < 8; k++) step(1, f[7-k], 1, 0);
    // Abort after five bits, x_valid in the clr cycle is dropped.
    for (int k = 0; k < 5; k++) step(1, k & 1, 0, 0);
    step(1, 1, 0, 1);
    send_frame(8'b1110_0000, 0, 0);
    // Asynchronous reset mid-frame, then a full frame.
    for (int k = 0; k < 3; k++) step(1, 1, 1, 0);
    #2;
    do_reset();
    send_frame(8'b0110_1011, 0, 0);
    // Five back-to-back frames wrong for the odd instance: saturate its 2-bit counter.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      f = 8'($urandom);
      p = ^f;
      send_frame(f, 1, p);
    end
    // Five back-to-back frames wrong for the even instance.
    for (int n = 0; n < 5; n++) begin
      f = 8'($urandom);
      p = (^f) ^ 1;
      send_frame(f, 1, p);
    end
    // Randomized traffic with gaps, mode flips and occasional aborts.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1),
           $urandom_range(0, 1), ($urandom_range(0, 59) == 0) ? 1 : 0);
    end
    repeat (3) step(0, 0, 0, 0);
    chk("final_drain0", q0.size(), 0);
    chk("final_drain1", q1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
